// File: rtl/key_deb_pkg.sv
// Shared types and default constants for the multi-channel key debouncer.
// The defaults give an 8 ms debounce window at a 20 MHz system clock.
package key_deb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCHK = 2'd1,
        HELD = 2'd2,
        RCHK = 2'd3
    } state_t;

    localparam int unsigned DEF_DEB_CYCLES = 160000;
    localparam int          DEF_CNT_W      = 18;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce/hold FSM with a shared counter,
// and registered level and event outputs.
module key_debounce_chan
    import key_deb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned LONG_CYCLES = 0,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);
    localparam bit               LONG_EN   = (LONG_CYCLES != 0);

    logic             s1;
    logic             s2;
    logic             act;
    logic             long_done;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    assign act = (s2 != IDLE_LEVEL);

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            s1            <= IDLE_LEVEL;
            s2            <= IDLE_LEVEL;
            state         <= IDLE;
            cnt           <= '0;
            long_done     <= 1'b0;
            key_level     <= IDLE_LEVEL;
            key_pressed   <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;

            // NOTE: strobes default low each cycle, so a pulse can never last two cycles.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (act) begin
                        state <= PCHK;
                        cnt   <= '0;
                    end
                end
                PCHK: begin
                    if (!act) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        long_done <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        key_pressed <= 1'b1;
                        key_level   <= ~IDLE_LEVEL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!act) begin
                        state <= RCHK;
                        cnt   <= '0;
                    end else if (LONG_EN && !long_done) begin
                        // Count stops at the threshold; long_done then blocks further counting.
                        if (cnt == LONG_LAST) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                RCHK: begin
                    if (act) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        long_done     <= 1'b0;
                        release_pulse <= 1'b1;
                        key_pressed   <= 1'b0;
                        key_level     <= IDLE_LEVEL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel key debouncer: one independent key_debounce_chan per key pin,
// plus elaboration-time sanity checks on the timing parameters.
module multi_key_debounce
    import key_deb_pkg::*;
#(
    parameter int          N_KEYS      = 4,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned LONG_CYCLES = 0,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 2");
    end

    // The counter reaches DEB_CYCLES-1 while debouncing and LONG_CYCLES while holding.
    if ($clog2(DEB_CYCLES) > CNT_W || $clog2(LONG_CYCLES + 1) > CNT_W) begin : g_bad_cnt_w
        $error("CNT_W too small for DEB_CYCLES / LONG_CYCLES");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .CNT_W      (CNT_W),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_chan (
            .sclk         (sclk),
            .rst_n        (rst_n),
            .key_raw      (key_raw[i]),
            .key_level    (key_level[i]),
            .key_pressed  (key_pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Bench for multi_key_debounce: run-length behavioural model compared every cycle,
// plus literal event-time expectations for the directed scenarios.
module tb_multi_key_debounce;

    localparam int N    = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;

    logic         sclk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_raw = 4'hF;
    logic [N-1:0] key_level, key_pressed, press_pulse, release_pulse, long_pulse;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    multi_key_debounce #(
        .N_KEYS     (N),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .CNT_W      (6),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .key_raw      (key_raw),
        .key_level    (key_level),
        .key_pressed  (key_pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // Model: a key flips its accepted state after DEB+1 consecutive synchronised samples
    // disagreeing with it; a hold fires long after LONG+1 agreeing samples since press/return.
    logic         d1 [N];
    logic         d2 [N];
    int           run [N];
    int           hold [N];
    bit           pressed [N];
    bit           ldone [N];
    logic [N-1:0] e_press, e_rel, e_long, e_pressed, e_level;

    always @(posedge sclk) begin
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                d1[i] = 1'b1; d2[i] = 1'b1;
                run[i] = 0; hold[i] = 0; pressed[i] = 1'b0; ldone[i] = 1'b0;
            end else begin
                bit a;
                a     = (d2[i] == 1'b0);
                d2[i] = d1[i];
                d1[i] = key_raw[i];
                if (!pressed[i]) begin
                    run[i] = a ? run[i] + 1 : 0;
                    if (run[i] == DEB + 1) begin
                        pressed[i] = 1'b1; e_press[i] = 1'b1; run[i] = 0; hold[i] = 0;
                    end
                end else if (!a) begin
                    run[i]++;
                    if (run[i] == DEB + 1) begin
                        pressed[i] = 1'b0; e_rel[i] = 1'b1; run[i] = 0; ldone[i] = 1'b0;
                    end
                end else if (run[i] > 0) begin
                    run[i] = 0; hold[i] = 0;
                end else begin
                    hold[i]++;
                    if (!ldone[i] && hold[i] == LONG + 1) begin
                        e_long[i] = 1'b1; ldone[i] = 1'b1;
                    end
                end
            end
            e_pressed[i] = pressed[i];
            e_level[i]   = ~pressed[i];
        end
    end

    always @(negedge sclk) begin
        if (check_en) begin
            check("key_level", 32'(key_level), 32'(e_level));
            check("key_pressed", 32'(key_pressed), 32'(e_pressed));
            check("press_pulse", 32'(press_pulse), 32'(e_press));
            check("release_pulse", 32'(release_pulse), 32'(e_rel));
            check("long_pulse", 32'(long_pulse), 32'(e_long));
        end
    end

    // Event log of the DUT's own strobes, for literal timing expectations.
    int p_cnt [N], r_cnt [N], l_cnt [N];
    int p_last [N], r_last [N], l_last [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            p_cnt[i] = 0; r_cnt[i] = 0; l_cnt[i] = 0;
            p_last[i] = -1; r_last[i] = -1; l_last[i] = -1;
        end
    end

    always @(negedge sclk) begin
        for (int i = 0; i < N; i++) begin
            if (press_pulse[i] === 1'b1)   begin p_cnt[i]++; p_last[i] = cyc; end
            if (release_pulse[i] === 1'b1) begin r_cnt[i]++; r_last[i] = cyc; end
            if (long_pulse[i] === 1'b1)    begin l_cnt[i]++; l_last[i] = cyc; end
        end
    end

    initial begin
        int t, h;
        int total;

        // Reset, then 50 idle cycles with no events.
        step(1);
        check_en = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(50);
        check("reset key_level", 32'(key_level), 32'hF);
        check("reset key_pressed", 32'(key_pressed), 32'h0);
        total = 0;
        for (int i = 0; i < N; i++) total += p_cnt[i] + r_cnt[i] + l_cnt[i];
        check("idle pulse count", 32'(total), 32'd0);

        // Clean press on channel 0.
        t = cyc;
        key_raw[0] = 1'b0;
        step(20);
        check("ch0 press count", 32'(p_cnt[0]), 32'd1);
        check("ch0 press time", 32'(p_last[0]), 32'(t + 11));
        check("ch0 key_pressed", 32'(key_pressed[0]), 32'd1);

        // Channel 1: 5-cycle glitch rejected, then a real press.
        key_raw[1] = 1'b0;
        step(5);
        key_raw[1] = 1'b1;
        step(30);
        check("ch1 glitch pulses", 32'(p_cnt[1] + r_cnt[1]), 32'd0);
        t = cyc;
        key_raw[1] = 1'b0;
        step(20);
        check("ch1 press count", 32'(p_cnt[1]), 32'd1);
        check("ch1 press time", 32'(p_last[1]), 32'(t + 11));

        // Channel 2: long press then release.
        t = cyc;
        key_raw[2] = 1'b0;
        step(60);
        h = cyc;
        key_raw[2] = 1'b1;
        step(20);
        check("ch2 press time", 32'(p_last[2]), 32'(t + 11));
        check("ch2 long count", 32'(l_cnt[2]), 32'd1);
        check("ch2 long time", 32'(l_last[2]), 32'(t + 44));
        check("ch2 release count", 32'(r_cnt[2]), 32'd1);
        check("ch2 release time", 32'(r_last[2]), 32'(h + 11));

        // Channel 3: held past long_pulse, then a 4-cycle release bounce.
        t = cyc;
        key_raw[3] = 1'b0;
        step(50);
        key_raw[3] = 1'b1;
        step(4);
        key_raw[3] = 1'b0;
        step(50);
        check("ch3 release count", 32'(r_cnt[3]), 32'd0);
        check("ch3 press count", 32'(p_cnt[3]), 32'd1);
        check("ch3 long count", 32'(l_cnt[3]), 32'd1);
        check("ch3 long time", 32'(l_last[3]), 32'(t + 44));

        // Release everything, then press all four in the same cycle.
        key_raw = 4'hF;
        step(20);
        check("all released", 32'(key_pressed), 32'h0);
        key_raw = 4'h0;
        step(11);
        check("simultaneous press", 32'(press_pulse), 32'hF);
        check("simultaneous held", 32'(key_pressed), 32'hF);
        key_raw = 4'hF;
        step(20);

        // Reset in the middle of a press debounce discards it.
        key_raw = 4'h0;
        step(6);
        total = 0;
        for (int i = 0; i < N; i++) total += p_cnt[i];
        rst_n = 1'b0;
        step(1);
        check("mid reset key_level", 32'(key_level), 32'hF);
        check("mid reset key_pressed", 32'(key_pressed), 32'h0);
        check("mid reset pulses", 32'(press_pulse | release_pulse | long_pulse), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(5);
        h = 0;
        for (int i = 0; i < N; i++) h += p_cnt[i];
        check("no press across reset", 32'(h - total), 32'd0);
        step(20);
        key_raw = 4'hF;
        step(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
